dcache_wb: RTL and testbench



---
 rtl/dcache_wb.sv | 78 +++++++
 tb/tb_dcache_wb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with 128-bit line fill/writeback.
// Hits complete in the request cycle; misses stall through an optional writeback followed by a fill.
module dcache_wb #(
  parameter int LINES = 8,
  parameter int IDX_W = 3,
  parameter int AW = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic proc_read,
  input  logic proc_write,
  input  logic [AW-1:0] proc_addr,
  input  logic [31:0] proc_wdata,
  output logic [31:0] proc_rdata,
  output logic proc_stall,
  output logic mem_read,
  output logic mem_write,
  output logic [AW-3:0] mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic mem_ready
);
  localparam int TW = AW - IDX_W - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t r_state, w_next;
  logic [LINES-1:0] r_valid, r_dirty;
  logic [LINES-1:0][TW-1:0] r_tag;
  logic [LINES-1:0][127:0] r_data;
  logic [IDX_W-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [6:0] w_bit;
  logic w_req, w_hit, w_idle;
  assign w_bit = {proc_addr[1:0], 5'b0};
  assign w_idx = proc_addr[IDX_W+1:2];
  assign w_tag = proc_addr[AW-1:IDX_W+2];
  assign w_req = proc_read | proc_write;
  assign w_idle = r_state == IDLE;
  assign w_hit = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign proc_stall = !w_idle || (w_req && !w_hit);
  // a simultaneous read and write is treated as a store, so no load data is returned
  assign proc_rdata = (w_idle && proc_read && !proc_write && w_hit) ? r_data[w_idx][w_bit +: 32] : 32'd0;
  assign mem_read = r_state == ALLOCATE;
  assign mem_write = r_state == WRITEBACK;
  assign mem_addr = {mem_write ? r_tag[w_idx] : w_tag, w_idx};
  assign mem_wdata = r_data[w_idx];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req && !w_hit) w_next = r_dirty[w_idx] ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ready) w_next = ALLOCATE;
      ALLOCATE: if (mem_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_tag <= '0;
      r_data <= '0;
    end else begin
      if (w_idle && proc_write && w_hit) begin
        r_data[w_idx][w_bit +: 32] <= proc_wdata;
        r_dirty[w_idx] <= 1'b1;
      end
      if (mem_write && mem_ready) r_dirty[w_idx] <= 1'b0;
      if (mem_read && mem_ready) begin
        r_data[w_idx] <= mem_rdata;
        r_tag[w_idx] <= w_tag;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed and randomized checks of dcache_wb against a flat word-memory reference
// plus a per-line residency model that predicts stalls, fills and writebacks.
module tb_dcache_wb;
  logic clk = 0, rst_n = 0, proc_read = 0, proc_write = 0, mem_ready = 0, spurious = 0;
  logic [29:0] proc_addr = '0;
  logic [31:0] proc_wdata = '0, proc_rdata;
  logic proc_stall, mem_read, mem_write;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata = '0;
  int vectors = 0, miscompares = 0, fill_n = 1, wb_n = 1, cnt = 0;
  logic [127:0] mem_line [logic [27:0]];
  logic [31:0] ref_w [logic [29:0]];
  logic m_valid [8], m_dirty [8];
  logic [24:0] m_tag [8];
  logic [27:0] fill_q [$], wb_aq [$];
  logic [127:0] wb_dq [$];
  logic [227:0] obs, exp_v;

  dcache_wb dut (.clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(logic [29:0] a);
    return a[29:2] == 28'd4 ? 32'(a[1:0]) + 32'd1 : {a, 2'b00} ^ 32'hA5C3_0F0F;
  endfunction

  function automatic logic [127:0] mem_get(logic [27:0] la);
    logic [127:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = init_word({la, 2'(k)});
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(logic [29:0] a);
    logic [127:0] l = mem_get(a[29:2]);
    return ref_w.exists(a) ? ref_w[a] : l[{a[1:0], 5'b0} +: 32];
  endfunction

  // memory responder: pulses mem_ready after fill_n / wb_n cycles of a held request
  initial forever begin
    @(negedge clk);
    mem_ready = 0;
    vectors++;
    if (mem_read && mem_write) begin
      miscompares++;
      $display("FAIL rd_wr_overlap: mem_read=%b mem_write=%b required not both", mem_read, mem_write);
    end
    if (!rst_n || !(mem_read || mem_write)) begin
      cnt = 0;
      if (spurious && rst_n) begin
        mem_ready = 1;
        mem_rdata = '1;
        spurious = 0;
      end
    end else if (++cnt >= (mem_write ? wb_n : fill_n)) begin
      cnt = 0;
      mem_ready = 1;
      if (mem_write) begin
        wb_aq.push_back(mem_addr);
        wb_dq.push_back(mem_wdata);
        mem_line[mem_addr] = mem_wdata;
      end else begin
        fill_q.push_back(mem_addr);
        mem_rdata = mem_get(mem_addr);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i] = '0;
    end
    ref_w.delete();
  endtask

  task automatic predict(input logic rd, input logic wr, input logic [29:0] a);
    int i = int'(a[4:2]);
    logic hit = m_valid[i] && m_tag[i] == a[29:5];
    logic wb = !hit && m_dirty[i];
    logic [27:0] oa = {m_tag[i], 3'(i)};
    logic [127:0] old;
    int st = hit ? 0 : 1 + fill_n + (wb ? wb_n : 0);
    for (int k = 0; k < 4; k++) old[32*k +: 32] = ref_rd({oa, 2'(k)});
    exp_v = {8'(st), (rd && !wr) ? ref_rd(a) : 32'd0, hit ? 2'd0 : 2'd1, hit ? 28'd0 : a[29:2],
             wb ? 2'd1 : 2'd0, wb ? oa : 28'd0, wb ? old : 128'd0};
  endtask

  task automatic commit(input logic wr, input logic [29:0] a, input logic [31:0] d);
    int i = int'(a[4:2]);
    if (!(m_valid[i] && m_tag[i] == a[29:5])) begin
      m_valid[i] = 1;
      m_tag[i] = a[29:5];
      m_dirty[i] = 0;
    end
    if (wr) begin
      ref_w[a] = d;
      m_dirty[i] = 1;
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    int st = 0;
    fill_q.delete();
    wb_aq.delete();
    wb_dq.delete();
    predict(rd, wr, a);
    proc_read = rd;
    proc_write = wr;
    proc_addr = a;
    proc_wdata = d;
    @(negedge clk);
    while (proc_stall && st < 200) begin
      st++;
      @(negedge clk);
    end
    obs = {8'(st), proc_rdata, 2'(fill_q.size()), fill_q.size() > 0 ? fill_q[0] : 28'd0,
           2'(wb_aq.size()), wb_aq.size() > 0 ? wb_aq[0] : 28'd0, wb_dq.size() > 0 ? wb_dq[0] : 128'd0};
    @(posedge clk);
    #1;
    proc_read = 0;
    proc_write = 0;
    commit(wr, a, d);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    vectors++;
    if ({mem_read, mem_write, proc_stall, proc_rdata} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%b wr=%b stall=%b rdata=%h required all 0", mem_read, mem_write, proc_stall, proc_rdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_fill();
    fill_n = 3;
    access(1, 0, 30'h10, 0);
    vectors++;
    if (obs !== exp_v || {obs[227:220], obs[219:188], obs[185:158]} !== {8'd4, 32'd1, 28'h4}) begin
      miscompares++;
      $display("FAIL first_fill: got %h required %h (stall 4, rdata 1, fill 0x4)", obs, exp_v);
    end
  endtask

  task automatic test_hits();
    for (int k = 1; k < 4; k++) begin
      access(1, 0, 30'h10 + 30'(k), 0);
      vectors++;
      if (obs !== exp_v || {obs[227:186], obs[157:156]} !== {8'd0, 32'(k + 1), 2'd0, 2'd0}) begin
        miscompares++;
        $display("FAIL hit_read_%0d: got %h required %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_writeback();
    access(0, 1, 30'h11, 32'hDEADBEEF);
    vectors++;
    if (obs !== exp_v || obs[227:220] !== 8'd0) begin
      miscompares++;
      $display("FAIL write_hit: got %h required %h", obs, exp_v);
    end
    wb_n = 2;
    fill_n = 2;
    access(1, 0, 30'h31, 0);
    vectors++;
    if (obs !== exp_v || {obs[155:128], obs[63:32], obs[185:158]} !== {28'h4, 32'hDEADBEEF, 28'hC}) begin
      miscompares++;
      $display("FAIL dirty_evict: got %h required %h (wb 0x4 word1 deadbeef, fill 0xc)", obs, exp_v);
    end
  endtask

  task automatic test_store_miss();
    fill_n = 1;
    wb_n = 3;
    access(0, 1, 30'h20, 32'h55);
    vectors++;
    if (obs !== exp_v || {obs[187:158], obs[157:156]} !== {2'd1, 28'h8, 2'd0}) begin
      miscompares++;
      $display("FAIL store_miss: got %h required %h", obs, exp_v);
    end
    access(1, 0, 30'h00, 0);
    vectors++;
    if (obs !== exp_v || {obs[155:128], obs[31:0]} !== {28'h8, 32'h55}) begin
      miscompares++;
      $display("FAIL store_miss_evict: got %h required %h (wb 0x8 word0 55)", obs, exp_v);
    end
  endtask

  task automatic test_rw_both();
    access(1, 0, 30'h10, 0);
    access(1, 1, 30'h10, 32'd7);
    vectors++;
    if (obs !== exp_v || obs[227:188] !== 40'd0) begin
      miscompares++;
      $display("FAIL rw_both: got %h required %h (no stall, rdata 0)", obs, exp_v);
    end
    access(1, 0, 30'h10, 0);
    vectors++;
    if (obs !== exp_v || obs[219:188] !== 32'd7) begin
      miscompares++;
      $display("FAIL rw_both_readback: got %h required %h (rdata 7)", obs, exp_v);
    end
  endtask

  task automatic test_idle_ready();
    spurious = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    access(1, 0, 30'h10, 0);
    vectors++;
    if (obs !== exp_v || obs[219:188] !== 32'd7) begin
      miscompares++;
      $display("FAIL idle_ready_ignored: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    fill_n = 20;
    proc_read = 1;
    proc_addr = 30'h14;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_alloc: mem_read=%b required 1", mem_read);
    end
    rst_n = 0;
    proc_read = 0;
    #1;
    vectors++;
    if ({mem_read, mem_write, proc_stall} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_alloc: got rd=%b wr=%b stall=%b required 000", mem_read, mem_write, proc_stall);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    fill_n = 2;
    access(1, 0, 30'h14, 0);
    vectors++;
    if (obs !== exp_v || obs[187:186] !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_refetch: got %h required %h", obs, exp_v);
    end
    access(1, 0, 30'h10, 0);
    vectors++;
    if (obs !== exp_v || obs[187:186] !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_invalidates: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int op = int'($urandom_range(0, 3));
      fill_n = int'($urandom_range(1, 4));
      wb_n = int'($urandom_range(1, 4));
      access(op != 2, op >= 2, 30'($urandom_range(0, 127)), $urandom);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_%0d: addr=%h op=%0d got %h required %h", n, proc_addr, op, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hits();
    test_writeback();
    test_store_miss();
    test_rw_both();
    test_idle_ready();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
